// File: rtl/rv32_pkg.sv
// Shared RV32 constants and types.
// Used by the register file and its read ports.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register file read port.
// Zero-detect, 32:1 select and optional write-to-read bypass.
module regfile_read_port
    import rv32_pkg::*;
#(
    parameter int XLEN   = rv32_pkg::XLEN,
    parameter int AW     = rv32_pkg::REG_AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic                       rst_n,
    input  logic [XLEN*(2**AW)-1:0]    regs_flat,
    input  logic                       we,
    input  logic [AW-1:0]              rd_addr,
    input  logic [XLEN-1:0]            rd_data,
    input  logic [AW-1:0]              rs_addr,
    output logic [XLEN-1:0]            rs_data
);

    logic            rs_zero;
    logic            hit;
    logic [XLEN-1:0] sel;

    assign rs_zero = (rs_addr == '0);

    // No forwarding while reset is held or for the x0 sink.
    assign hit = BYPASS && rst_n && we &&
                 (rd_addr != '0) &&
                 (rd_addr == rs_addr);

    assign sel = regs_flat[int'(rs_addr)*XLEN +: XLEN];

    always_comb begin
        rs_data = sel;
        if (rs_zero)
            rs_data = '0;
        else if (hit)
            rs_data = rd_data;
    end

endmodule

// File: rtl/regfile.sv
// RV32 integer register file: 2 read ports, 1 write port.
// x0 has no storage and always reads zero.
module regfile
    import rv32_pkg::*;
#(
    parameter int XLEN   = rv32_pkg::XLEN,
    parameter int AW     = rv32_pkg::REG_AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data
);

    localparam int NREG = 2**AW;

    logic [XLEN*NREG-1:0] regs_flat;

    assign regs_flat[XLEN-1:0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [XLEN-1:0] q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= '0;
            else if (we && (rd_addr == AW'(i)))
                q <= rd_data;
        end

        assign regs_flat[i*XLEN +: XLEN] = q;
    end

    regfile_read_port #(
        .XLEN   (XLEN),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_rs1 (
        .rst_n     (rst_n),
        .regs_flat (regs_flat),
        .we        (we),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rs_addr   (rs1_addr),
        .rs_data   (rs1_data)
    );

    regfile_read_port #(
        .XLEN   (XLEN),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_rs2 (
        .rst_n     (rst_n),
        .regs_flat (regs_flat),
        .we        (we),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rs_addr   (rs2_addr),
        .rs_data   (rs2_data)
    );

endmodule

// File: tb/tb_regfile.sv
// Randomized self-checking bench for regfile.
// Checks a bypassing and a non-bypassing instance against an array model.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] rs1_data_nb;
    logic [31:0] rs2_data_nb;

    logic [31:0] mdl [32];
    int n_chk;
    int n_fail;

    regfile #(.XLEN(32), .AW(5), .BYPASS(1'b1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    regfile #(.XLEN(32), .AW(5), .BYPASS(1'b0)) u_dut_nb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data_nb),
        .rs2_data (rs2_data_nb),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a,
                                           input bit byp);
        if (a == 5'd0)
            return 32'h0;
        if (byp && rst_n && we && rd_addr != 5'd0 && rd_addr == a)
            return rd_data;
        return mdl[a];
    endfunction

    task automatic check_reads(input string tag);
        chk({tag, ".rs1"}, rs1_data, ref_rd(rs1_addr, 1'b1));
        chk({tag, ".rs2"}, rs2_data, ref_rd(rs2_addr, 1'b1));
        chk({tag, ".rs1_nb"}, rs1_data_nb, ref_rd(rs1_addr, 1'b0));
        chk({tag, ".rs2_nb"}, rs2_data_nb, ref_rd(rs2_addr, 1'b0));
    endtask

    // Drive after the falling edge, check before and after the rising edge.
    task automatic cycle(input string tag,
                         input logic w,
                         input logic [4:0] rd,
                         input logic [31:0] wd,
                         input logic [4:0] a1,
                         input logic [4:0] a2);
        we       = w;
        rd_addr  = rd;
        rd_data  = wd;
        rs1_addr = a1;
        rs2_addr = a2;
        #2;
        check_reads({tag, ".pre"});
        @(posedge clk);
        if (rst_n && w && rd != 5'd0)
            mdl[rd] = wd;
        #1;
        we = 1'b0;
        #1;
        check_reads({tag, ".post"});
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rst_n    = 1'b0;
        we       = 1'b0;
        rd_addr  = 5'd0;
        rd_data  = 32'h0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        repeat (2) @(negedge clk);

        // Reset state: every register reads zero.
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check_reads("reset");
        end
        rst_n = 1'b1;
        @(negedge clk);

        cycle("wr3", 1'b1, 5'd3, 32'h0000ffff, 5'd3, 5'd4);
        cycle("wr4", 1'b1, 5'd4, 32'hffff0000, 5'd3, 5'd4);
        cycle("rd34", 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        chk("x3_val", rs1_data, 32'h0000ffff);
        chk("x4_val", rs2_data, 32'hffff0000);

        cycle("x0w", 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd3);
        cycle("x0r", 1'b0, 5'd0, 32'h0, 5'd0, 5'd4);
        chk("x0_val", rs1_data, 32'h0);

        cycle("x7a", 1'b1, 5'd7, 32'h1, 5'd1, 5'd2);
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h00ffff00;
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        #2;
        chk("byp_rs1", rs1_data, 32'h00ffff00);
        chk("byp_rs2", rs2_data, 32'h00ffff00);
        chk("nobyp_rs1", rs1_data_nb, 32'h1);
        chk("nobyp_rs2", rs2_data_nb, 32'h1);
        @(posedge clk);
        mdl[7] = 32'h00ffff00;
        #1;
        we = 1'b0;
        #1;
        chk("nobyp_post", rs1_data_nb, 32'h00ffff00);
        check_reads("x7post");
        @(negedge clk);

        // Asynchronous reset in the middle of the low phase.
        cycle("x5", 1'b1, 5'd5, 32'hdeadbeef, 5'd5, 5'd5);
        rs1_addr = 5'd5;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        #1;
        chk("arst_x5", rs1_data, 32'h0);
        check_reads("arst");
        @(negedge clk);

        cycle("rstw1", 1'b1, 5'd9, 32'hffffffff, 5'd9, 5'd9);
        cycle("rstw2", 1'b1, 5'd9, 32'hffffffff, 5'd9, 5'd9);
        rst_n = 1'b1;
        @(negedge clk);
        cycle("x9", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        chk("x9_val", rs1_data, 32'h0);

        // Sweep every register.
        for (int i = 1; i < 32; i++)
            cycle("sweep_w", 1'b1, 5'(i), 32'(i) * 32'h01010101,
                  5'(i), 5'(32 - i));
        for (int i = 1; i < 32; i++) begin
            cycle("sweep_r", 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
            chk("sweep_val", rs2_data, 32'(i) * 32'h01010101);
        end

        // Random traffic, biased towards read/write address matches.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a1;
            logic [4:0] a2;
            logic [4:0] rd;
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: rd = a1;
                1: rd = a2;
                default: ;
            endcase
            cycle("rand", 1'($urandom_range(0, 1)), rd, $urandom, a1, a2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- RV32 integer register file: 32 x 32-bit registers, two combinational read ports, one synchronous write port.
- Sits directly upstream of the 32-bit 2:1 operand selector. rs1_data and rs2_data feed the selector's input_a path (and the store-data path).
- Register x0 is hardwired to zero.
- An optional write-to-read bypass lets an instruction in decode see a value being written back in the same cycle.

Parameters:
- XLEN, 32, data width of each register and port.
- AW, 5, register address width (2**AW registers).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = read returns pre-write contents.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all registers.
- rs1_addr  input  AW  read port 1 register index.
- rs2_addr  input  AW  read port 2 register index.
- rs1_data  output  XLEN  read port 1 data (combinational).
- rs2_data  output  XLEN  read port 2 data (combinational).
- we  input  1  write enable, sampled on clk rising edge.
- rd_addr  input  AW  write register index.
- rd_data  input  XLEN  write data.

Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Storage: registers x1..x31 are flops. x0 has no storage and always reads 0.
- Reset: rst_n low immediately (asynchronously) clears x1..x31 to 0. While rst_n is low:
  - writes are ignored;
  - rs1_data and rs2_data equal the contents of the addressed register, which is 0 after the clear;
  - bypass is suppressed.
- Reset release: takes effect at any time. The first write is accepted on the first rising clk edge with rst_n high.
- Write: on rising clk edge, if rst_n high, we=1 and rd_addr!=0, then reg[rd_addr] <= rd_data. A write with rd_addr=0 is discarded with no side effect.
- Read: rsN_data = 0 if rsN_addr==0; otherwise bypass value if active; otherwise reg[rsN_addr]. Pure combinational, zero-cycle latency.
- Bypass (BYPASS=1): when rst_n=1, we=1, rd_addr!=0 and rd_addr==rsN_addr, rsN_data = rd_data in the same cycle, before the edge.
  - Both ports may bypass simultaneously when rs1_addr==rs2_addr==rd_addr.
- BYPASS=0: rsN_data shows the old value until after the edge, then the new value.
- Consecutive writes to the same register: the last one wins; one write per cycle.
- No X propagation: every output is defined for every input combination once reset has been applied.
- Address width is exact: no out-of-range index exists for AW=5.

Decomposition:
- Shared package rv32_pkg:
  - XLEN = 32;
  - REG_AW = 5;
  - REG_ZERO = 5'd0;
  - typedef word_t (XLEN bits);
  - typedef reg_idx_t (REG_AW bits).
- Sub-module regfile_read_port: zero-detect + 32:1 mux + bypass compare. Instantiated twice (rs1, rs2); takes the flattened register array, the write-side signals and the BYPASS parameter.

Test Plan:
- Reset: after writing x5=32'hdeadbeef, pulse rst_n low mid-cycle (not on an edge) -> rs1_data reads 0 for x5 immediately, before the next clk edge.
- Write/read: we=1, rd_addr=3, rd_data=32'h0000ffff, then rd_addr=4, rd_data=32'hffff0000 -> next cycle rs1_addr=3 gives 32'h0000ffff and rs2_addr=4 gives 32'hffff0000.
- x0: we=1, rd_addr=0, rd_data=32'h12345678 -> rs1_addr=0 reads 0 in the same cycle and every later cycle; no other register changes.
- Bypass: BYPASS=1, x7 holds 32'h1, we=1, rd_addr=7, rd_data=32'h00ffff00, rs1_addr=rs2_addr=7 -> both outputs show 32'h00ffff00 before the edge. With BYPASS=0 they show 32'h1 before the edge and 32'h00ffff00 after it.
- Write during reset: rst_n=0, we=1, rd_addr=9, rd_data=32'hffffffff across two edges -> after release, x9 reads 0.
- Sweep: write x_i = i*32'h01010101 for i=1..31 -> read back all 31 values on both ports, each matching.
